pifo_port_queue: RTL and testbench

PIFO_PORT_QUEUE -- requirements
Module: pifo_port_queue

---
 rtl/pifo_port_queue.sv | 111 +++++++++++
 tb/tb_pifo_port_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pifo_port_queue.sv
// Sorted-shift PIFO for one output port: ascending 13-bit key, FIFO on ties.
// Define PIFO_QUEUE_DROP_CNT_EN to enable the saturating drop counter.
module pifo_port_queue #(
  parameter int DEPTH        = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int KEY_WIDTH    = 13
) (
  input  logic                      clk_dp,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [RESULT_WIDTH-1:0]   in_data,
  output logic                      in_ready,
  input  logic                      deq_req,
  output logic                      out_valid,
  output logic [RESULT_WIDTH-1:0]   out_data,
  output logic [RESULT_WIDTH-1:0]   wire_out_last_pkt_info,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic [15:0]               drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = 12;

  logic [RESULT_WIDTH-1:0] ent_q [DEPTH];
  logic [RESULT_WIDTH-1:0] ent_d [DEPTH];
  logic [RESULT_WIDTH-1:0] post  [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, cnt_post;
  logic [DEPTH-1:0] le;
  logic out_valid_q, out_valid_d;
  logic [RESULT_WIDTH-1:0] out_data_q, out_data_d;
  logic enq_v, enq_ok, deq_ok;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign in_ready = ~full;
  assign count    = cnt_q;

  assign enq_v  = in_valid & in_data[RESULT_WIDTH-1];
  assign enq_ok = enq_v & ~full;
  assign deq_ok = deq_req & ~empty;

  // Insert position is found against the array after this cycle's pop.
  always_comb begin
    for (int i = 0; i < DEPTH-1; i++)
      post[i] = deq_ok ? ent_q[i+1] : ent_q[i];
    post[DEPTH-1] = deq_ok ? '0 : ent_q[DEPTH-1];
    cnt_post = cnt_q - CW'(deq_ok);
    for (int i = 0; i < DEPTH; i++)
      le[i] = (CW'(i) < cnt_post) &&
              (post[i][IW+KEY_WIDTH-1:IW] <=
               in_data[IW+KEY_WIDTH-1:IW]);
  end

  // le is a run of ones: keep those, drop new entry at the first zero.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ent_d[i] = post[i];
    if (enq_ok) begin
      if (!le[0])
        ent_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (!le[i])
          ent_d[i] = le[i-1] ? in_data : post[i-1];
      end
    end
    cnt_d       = cnt_post + CW'(enq_ok);
    out_valid_d = deq_ok;
    out_data_d  = deq_ok ? ent_q[0] : out_data_q;
  end

  always_ff @(posedge clk_dp or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid              = out_valid_q;
  assign out_data               = out_data_q;
  assign wire_out_last_pkt_info = out_data_q;

`ifdef PIFO_QUEUE_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (enq_v && full && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_dp or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pifo_port_queue.sv
// Bench for pifo_port_queue: vector table, scoreboard model, corner sequences.
module tb_pifo_port_queue;
  localparam int DEPTH = 16;

  logic        clk_dp = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        deq_req = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [31:0] wire_out_last_pkt_info;
  logic [4:0]  count;
  logic        full, empty;
  logic [15:0] drop_cnt;

  pifo_port_queue #(.DEPTH(16), .RESULT_WIDTH(32), .KEY_WIDTH(13)) dut (
    .clk_dp(clk_dp), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .deq_req(deq_req), .out_valid(out_valid),
    .out_data(out_data), .wire_out_last_pkt_info(wire_out_last_pkt_info),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  always #5 clk_dp = ~clk_dp;

  int checks = 0;
  int failures = 0;
  logic [31:0] mq[$];
  logic [31:0] sb[$];
  logic [31:0] last_exp = '0;
  logic [15:0] mdrop = '0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        dq;
    int          cnt;
    logic        pulse;
    logic [11:0] info;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] cls,
                                     input logic [12:0] key,
                                     input logic [11:0] info);
    return {1'b1, cls, key, info};
  endfunction

  task automatic chk_rst(input string nm);
    chk({nm, "_count"}, 32'(count), 0);
    chk({nm, "_empty"}, 32'(empty), 1);
    chk({nm, "_full"}, 32'(full), 0);
    chk({nm, "_in_ready"}, 32'(in_ready), 1);
    chk({nm, "_out_valid"}, 32'(out_valid), 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_last_info"}, wire_out_last_pkt_info, 0);
    chk({nm, "_drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic dq);
    int pos;
    logic [31:0] e;
    logic was_full, pulse;
    @(negedge clk_dp);
    in_valid = v;
    in_data  = d;
    deq_req  = dq;
    was_full = (mq.size() == DEPTH);
    pulse    = dq && (mq.size() > 0);
    if (pulse) begin
      e = mq.pop_front();
      sb.push_back(e);
      last_exp = e;
    end
    if (v && d[31]) begin
      if (was_full) begin
`ifdef PIFO_QUEUE_DROP_CNT_EN
        if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
`endif
      end else begin
        pos = 0;
        foreach (mq[i])
          if (mq[i][24:12] <= d[24:12]) pos = i + 1;
        mq.insert(pos, d);
      end
    end
    @(posedge clk_dp);
    #1;
    chk("out_valid", 32'(out_valid), 32'(pulse));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (out_valid) chk("sb_out_data", out_data, e);
    end
    chk("out_data_hold", out_data, last_exp);
    chk("last_info", wire_out_last_pkt_info, last_exp);
    chk("count", 32'(count), mq.size());
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] drop_exp;

    // Class bits of the first key-2 entry must not affect ordering.
    tv[0] = '{1'b1, mk(6'h00, 13'd5, 12'hA), 1'b0, 1, 1'b0, 12'h0};
    tv[1] = '{1'b1, mk(6'h3F, 13'd2, 12'hB), 1'b0, 2, 1'b0, 12'h0};
    tv[2] = '{1'b1, mk(6'h00, 13'd9, 12'hC), 1'b0, 3, 1'b0, 12'h0};
    tv[3] = '{1'b1, mk(6'h00, 13'd2, 12'hD), 1'b0, 4, 1'b0, 12'h0};
    tv[4] = '{1'b0, 32'h0, 1'b1, 3, 1'b1, 12'hB};
    tv[5] = '{1'b0, 32'h0, 1'b1, 2, 1'b1, 12'hD};
    tv[6] = '{1'b0, 32'h0, 1'b1, 1, 1'b1, 12'hA};
    tv[7] = '{1'b0, 32'h0, 1'b1, 0, 1'b1, 12'hC};

    #2;
    chk_rst("reset");
    #10 rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(tv[i].v, tv[i].d, tv[i].dq);
      chk("vec_count", 32'(count), tv[i].cnt);
      chk("vec_pulse", 32'(out_valid), 32'(tv[i].pulse));
      if (tv[i].pulse) chk("vec_info", 32'(out_data[11:0]), 32'(tv[i].info));
    end

    // Full queue: simultaneous enq+deq pops head and drops the new entry.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk(6'h0, 13'(100 + i), 12'(i)), 1'b0);
    step(1'b1, mk(6'h0, 13'd1, 12'hEEE), 1'b1);
    chk("full_deq_pulse", 32'(out_valid), 1);
    chk("full_deq_info", 32'(out_data[11:0]), 0);
    chk("full_deq_count", 32'(count), 15);
`ifdef PIFO_QUEUE_DROP_CNT_EN
    drop_exp = 16'd1;
`else
    drop_exp = 16'd0;
`endif
    chk("full_deq_drop", 32'(drop_cnt), 32'(drop_exp));
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1);

    // Empty queue: enqueue accepted, dequeue ignored, no bypass.
    step(1'b1, mk(6'h0, 13'd7, 12'h077), 1'b1);
    chk("empty_enq_pulse", 32'(out_valid), 0);
    chk("empty_enq_count", 32'(count), 1);
    step(1'b0, 32'h0, 1'b1);
    chk("empty_enq_key", 32'(out_data[24:12]), 7);

    // Invalid entry (bit 31 low) is ignored.
    step(1'b1, 32'h7FFF_FFFF, 1'b0);
    chk("invalid_count", 32'(count), 0);

    step(1'b1, {1'b1, 19'h00805, 12'h03C}, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("last_rank", 32'(wire_out_last_pkt_info[30:12]), 32'h00805);
      if (i < 3) idle();
    end

    for (int i = 0; i < 400; i++) begin
      d = {($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
           6'($urandom), 13'($urandom_range(0, 15)), 12'($urandom)};
      step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) == 0));
    end
    while (mq.size() > 0) step(1'b0, 32'h0, 1'b1);

    // Mid-operation reset with a dequeue in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(6'h0, 13'(3 - i), 12'(i)), 1'b0);
    @(negedge clk_dp);
    in_valid = 1'b0;
    deq_req  = 1'b1;
    #2 rst = 1'b0;
    #1 chk_rst("async_rst");
    mq.delete();
    sb.delete();
    last_exp = '0;
    mdrop = '0;
    @(posedge clk_dp);
    #1 chk_rst("rst_held");
    @(negedge clk_dp);
    deq_req = 1'b0;
    #1 rst = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    chk("post_rst_pulse", 32'(out_valid), 0);
    chk("post_rst_empty", 32'(empty), 1);

`ifdef PIFO_QUEUE_DROP_CNT_EN
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk(6'h0, 13'(i), 12'(i)), 1'b0);
    for (int i = 0; i < 32'h10000; i++)
      step(1'b1, mk(6'h0, 13'd0, 12'h0), 1'b0);
    chk("drop_sat", 32'(drop_cnt), 32'hFFFF);
    step(1'b1, mk(6'h0, 13'd0, 12'h0), 1'b0);
    chk("drop_sat_hold", 32'(drop_cnt), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
